// File: rtl/ice_sl_arbiter_pkg.sv
// Shared constants for the slave-bus response arbiter and its helpers.
package ice_sl_arbiter_pkg;

  localparam int ICE_SL_NUM_DEV = 7;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GRANT = 2'd1;
  localparam logic [1:0] ARB_GAP   = 2'd2;

endpackage

// File: rtl/ice_rr_pick.sv
// Circular first-one finder: the lowest set bit of cand at or above ptr,
// wrapping around at NUM_DEV. Purely combinational, reusable by any arbiter.
module ice_rr_pick #(
  parameter int NUM_DEV = 7,
  parameter int ID_W    = 3
) (
  input  logic [NUM_DEV-1:0] cand,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    pick_id,
  output logic               pick_valid
);

  logic [ID_W:0]   idx;
  logic [ID_W-1:0] idx_w;

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    idx_w      = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_DEV)) begin
        idx = idx - (ID_W+1)'(NUM_DEV);
      end
      idx_w = idx[ID_W-1:0];
      if (!pick_valid && cand[idx_w]) begin
        pick_valid = 1'b1;
        pick_id    = idx_w;
      end
    end
  end

endmodule

// File: rtl/ice_sl_arbiter.sv
// Round-robin owner of the shared slave response bus, with a high-priority
// class, a per-message hold watchdog and a dead-cycle gap between owners.
//
//   state     | meaning
//   ARB_IDLE  | no owner; a grant is issued as soon as a candidate exists
//   ARB_GRANT | one source owns the bus; hold watchdog running
//   ARB_GAP   | bus released; idle GAP_CYCLES before the next grant
module ice_sl_arbiter
  import ice_sl_arbiter_pkg::*;
#(
  parameter int NUM_DEV    = ICE_SL_NUM_DEV,
  parameter int ID_W       = 3,
  parameter int GAP_CYCLES = 1,
  parameter int TMO_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DEV-1:0] sl_arb_request,
  input  logic [NUM_DEV-1:0] req_enable,
  input  logic [NUM_DEV-1:0] hi_prio,
  input  logic [TMO_W-1:0]   timeout_cycles,
  output logic [NUM_DEV-1:0] sl_arb_grant,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout_pulse,
  output logic [ID_W-1:0]    timeout_id
);

  logic [1:0]         state_q, state_d;
  logic [NUM_DEV-1:0] grant_q, grant_d;
  logic [NUM_DEV-1:0] blocked_q, blocked_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    tmo_id_q, tmo_id_d;
  logic [TMO_W-1:0]   hold_ctr_q, hold_ctr_d;
  logic [3:0]         gap_ctr_q, gap_ctr_d;
  logic               tmo_pulse_q, tmo_pulse_d;

  logic [NUM_DEV-1:0] eligible, hi_cand, cand;
  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic               owner_live;
  logic               watchdog_hit;

  assign eligible = sl_arb_request & req_enable & ~blocked_q;
  assign hi_cand  = eligible & hi_prio;
  assign cand     = (hi_cand != '0) ? hi_cand : eligible;

  ice_rr_pick #(
    .NUM_DEV (NUM_DEV),
    .ID_W    (ID_W)
  ) u_pick (
    .cand       (cand),
    .ptr        (rr_ptr_q),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  assign owner_live   = sl_arb_request[grant_id_q] & req_enable[grant_id_q];
  assign watchdog_hit = (timeout_cycles != '0) &&
                        (hold_ctr_q == timeout_cycles - TMO_W'(1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    tmo_id_d    = tmo_id_q;
    hold_ctr_d  = hold_ctr_q;
    gap_ctr_d   = gap_ctr_q;
    tmo_pulse_d = 1'b0;
    // A source that lets go of its request is forgiven for any earlier revoke.
    blocked_d   = blocked_q & sl_arb_request;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          grant_id_d       = pick_id;
          rr_ptr_d         = (pick_id == ID_W'(NUM_DEV-1)) ? '0 : pick_id + ID_W'(1);
          hold_ctr_d       = '0;
          state_d          = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!owner_live) begin
          grant_d   = '0;
          gap_ctr_d = 4'(GAP_CYCLES-1);
          state_d   = ARB_GAP;
        end else if (watchdog_hit) begin
          grant_d               = '0;
          tmo_pulse_d           = 1'b1;
          tmo_id_d              = grant_id_q;
          blocked_d[grant_id_q] = 1'b1;
          gap_ctr_d             = 4'(GAP_CYCLES-1);
          state_d               = ARB_GAP;
        end else if (hold_ctr_q != '1) begin
          hold_ctr_d = hold_ctr_q + TMO_W'(1);
        end
      end
      ARB_GAP: begin
        if (gap_ctr_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          gap_ctr_d = gap_ctr_q - 4'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      blocked_q   <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      tmo_id_q    <= '0;
      hold_ctr_q  <= '0;
      gap_ctr_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      blocked_q   <= blocked_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      tmo_id_q    <= tmo_id_d;
      hold_ctr_q  <= hold_ctr_d;
      gap_ctr_q   <= gap_ctr_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign sl_arb_grant  = grant_q;
  assign busy          = (state_q != ARB_IDLE);
  assign grant_id      = grant_id_q;
  assign timeout_pulse = tmo_pulse_q;
  assign timeout_id    = tmo_id_q;

endmodule

// File: tb/tb_ice_sl_arbiter.sv
// Directed bench for ice_sl_arbiter: expected grant/release/timeout events are
// queued up front and matched by a negedge monitor as the DUT produces them.
module tb_ice_sl_arbiter;

  localparam int N = 7;
  localparam int EV_OFF = 0;
  localparam int EV_ON  = 1;
  localparam int EV_TMO = 2;

  typedef struct {
    int kind;
    int id;
    int cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] sl_arb_request;
  logic [N-1:0] req_enable;
  logic [N-1:0] hi_prio;
  logic [15:0]  timeout_cycles;
  logic [N-1:0] sl_arb_grant;
  logic         busy;
  logic [2:0]   grant_id;
  logic         timeout_pulse;
  logic [2:0]   timeout_id;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t exp_q[$];
  logic [N-1:0] prev_grant = '0;

  ice_sl_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .sl_arb_request (sl_arb_request),
    .req_enable     (req_enable),
    .hi_prio        (hi_prio),
    .timeout_cycles (timeout_cycles),
    .sl_arb_grant   (sl_arb_grant),
    .busy           (busy),
    .grant_id       (grant_id),
    .timeout_pulse  (timeout_pulse),
    .timeout_id     (timeout_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int oh_idx(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic expect_ev(input int kind, input int id, input int c);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int id);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d id=%0d cyc=%0d", kind, id, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.id != id || e.cyc != cyc) begin
        failures++;
        $display("FAIL event got kind=%0d id=%0d cyc=%0d required kind=%0d id=%0d cyc=%0d",
                 kind, id, cyc, e.kind, e.id, e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one-hot invariant every cycle plus event matching.
  always @(negedge clk) begin
    checks++;
    if ($countones(sl_arb_grant) > 1) begin
      failures++;
      $display("FAIL grant_onehot cyc=%0d got=%b required=at_most_one_bit", cyc, sl_arb_grant);
    end
    if (prev_grant != '0 && sl_arb_grant != prev_grant) got_ev(EV_OFF, oh_idx(prev_grant));
    if (sl_arb_grant != '0 && sl_arb_grant != prev_grant) got_ev(EV_ON, oh_idx(sl_arb_grant));
    if (timeout_pulse) got_ev(EV_TMO, int'(timeout_id));
    prev_grant = sl_arb_grant;
  end

  initial begin
    reset          = 1'b1;
    sl_arb_request = '0;
    req_enable     = '1;
    hi_prio        = '0;
    timeout_cycles = '0;

    at(2);
    chk("rst_grant", 32'(sl_arb_grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_tmo_pulse", 32'(timeout_pulse), 32'd0);
    chk("rst_tmo_id", 32'(timeout_id), 32'd0);
    at(3); reset = 1'b0;

    // Single source 5: held cycles 10..29
    expect_ev(EV_ON, 5, 11);
    expect_ev(EV_OFF, 5, 31);
    at(10); chk("t1_busy_before", 32'(busy), 32'd0);
    sl_arb_request[5] = 1'b1;
    at(11); chk("t1_busy_grant", 32'(busy), 32'd1);
    chk("t1_grant_id", 32'(grant_id), 32'd5);
    at(30); sl_arb_request[5] = 1'b0;
    at(31); chk("t1_busy_gap", 32'(busy), 32'd1);
    at(32); chk("t1_busy_after", 32'(busy), 32'd0);

    // Round robin from a fresh pointer
    at(38); reset = 1'b1;
    at(39); reset = 1'b0;
    expect_ev(EV_ON, 0, 41);  expect_ev(EV_OFF, 0, 46);
    expect_ev(EV_ON, 2, 48);  expect_ev(EV_OFF, 2, 53);
    expect_ev(EV_ON, 6, 55);  expect_ev(EV_OFF, 6, 60);
    expect_ev(EV_ON, 0, 62);  expect_ev(EV_OFF, 0, 67);
    at(40); sl_arb_request = 7'b1000101;
    at(45); sl_arb_request[0] = 1'b0;
    at(46); sl_arb_request[0] = 1'b1;
    at(52); sl_arb_request[2] = 1'b0;
    at(53); sl_arb_request[2] = 1'b1;
    at(59); sl_arb_request[6] = 1'b0;
    at(60); sl_arb_request[6] = 1'b1;
    at(66); sl_arb_request[0] = 1'b0;
    at(67); sl_arb_request = '0;

    // Priority: 3 beats 1; later hi_prio 3 does not preempt 1
    expect_ev(EV_ON, 3, 76);  expect_ev(EV_OFF, 3, 81);
    expect_ev(EV_ON, 1, 83);  expect_ev(EV_OFF, 1, 91);
    expect_ev(EV_ON, 3, 93);  expect_ev(EV_OFF, 3, 97);
    at(75); hi_prio = 7'b0001000; sl_arb_request = 7'b0001010;
    at(80); sl_arb_request[3] = 1'b0;
    at(81); hi_prio = '0;
    at(85); hi_prio = 7'b0001000; sl_arb_request[3] = 1'b1;
    at(86); chk("t3_no_preempt", 32'(grant_id), 32'd1);
    at(90); sl_arb_request[1] = 1'b0;
    at(96); sl_arb_request[3] = 1'b0;
    at(97); hi_prio = '0;

    // Watchdog revokes source 2 after 8 cycles; 4 goes next; 2 blocked until re-raise
    expect_ev(EV_ON, 2, 106);
    expect_ev(EV_OFF, 2, 114); expect_ev(EV_TMO, 2, 114);
    expect_ev(EV_ON, 4, 116);  expect_ev(EV_OFF, 4, 121);
    expect_ev(EV_ON, 2, 128);  expect_ev(EV_OFF, 2, 131);
    at(105); timeout_cycles = 16'd8; sl_arb_request[2] = 1'b1;
    at(108); sl_arb_request[4] = 1'b1;
    at(120); sl_arb_request[4] = 1'b0;
    at(125); chk("t4_blocked_idle", 32'(busy), 32'd0);
    chk("t4_tmo_id_sticky", 32'(timeout_id), 32'd2);
    at(126); sl_arb_request[2] = 1'b0;
    at(127); sl_arb_request[2] = 1'b1;
    at(130); sl_arb_request[2] = 1'b0;

    // Enable drop releases without pulse or block
    expect_ev(EV_ON, 4, 136);  expect_ev(EV_OFF, 4, 140);
    expect_ev(EV_ON, 4, 142);  expect_ev(EV_OFF, 4, 145);
    at(135); sl_arb_request[4] = 1'b1;
    at(139); req_enable[4] = 1'b0;
    at(141); req_enable[4] = 1'b1;
    at(144); sl_arb_request[4] = 1'b0;
    at(146); chk("t5_tmo_id_kept", 32'(timeout_id), 32'd2);

    // Watchdog disabled: long hold saturates the hold counter
    expect_ev(EV_ON, 0, 151);  expect_ev(EV_OFF, 0, 70153);
    at(150); timeout_cycles = '0; sl_arb_request[0] = 1'b1;
    at(70151);
    chk("t5_long_grant", 32'(sl_arb_grant), 32'h01);
    chk("t5_hold_sat", 32'(dut.hold_ctr_q), 32'h0000FFFF);
    at(70152); sl_arb_request[0] = 1'b0;

    // Reset mid-grant clears everything, pointer back to 0
    expect_ev(EV_ON, 1, 70161); expect_ev(EV_OFF, 1, 70166);
    expect_ev(EV_ON, 0, 70167); expect_ev(EV_OFF, 0, 70171);
    at(70160); sl_arb_request[1] = 1'b1;
    at(70165); reset = 1'b1; sl_arb_request[0] = 1'b1;
    at(70166); reset = 1'b0;
    chk("t6_grant", 32'(sl_arb_grant), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_grant_id", 32'(grant_id), 32'd0);
    chk("t6_tmo_pulse", 32'(timeout_pulse), 32'd0);
    chk("t6_tmo_id", 32'(timeout_id), 32'd0);
    at(70167); chk("t6_first_pick", 32'(grant_id), 32'd0);
    at(70170); sl_arb_request = '0;

    at(70180);
    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
